// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set bit of req_i scanning from ptr_i upward, wrapping at N.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int pos;

  // Explicit wrap compare so non-power-of-two N never aliases onto a missing requester.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers.
// Define FIFO_ARB_PKT_EN for packet mode: grants are held until an accepted beat with req_last set.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  localparam int IW       = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
`ifdef FIFO_ARB_PKT_EN
  input  logic [NUM_REQ-1:0]       req_last,
  output logic                     out_last,
`endif
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            grant_idx,
  output logic                     busy
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] next_ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          g_valid, g_accept, release_w;

`ifndef FIFO_ARB_PKT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
`endif

  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign busy     = (state_q == ARB_GRANT);
  assign g_valid  = req_valid[grant_q];
  assign g_accept = busy && g_valid && out_ready;
  assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

`ifdef FIFO_ARB_PKT_EN
  // A packet is never interleaved: only its last accepted beat ends the grant.
  assign release_w = g_accept && req_last[grant_q];
  assign out_last  = busy && req_last[grant_q];
`else
  assign release_w = !g_valid || (g_accept && beat_cnt_q == CW'(MAX_BURST - 1));
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifndef FIFO_ARB_PKT_EN
    beat_cnt_d = beat_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
`ifndef FIFO_ARB_PKT_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (release_w) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
`ifndef FIFO_ARB_PKT_EN
          beat_cnt_d = '0;
`endif
        end
`ifndef FIFO_ARB_PKT_EN
        else if (g_accept) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifndef FIFO_ARB_PKT_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifndef FIFO_ARB_PKT_EN
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

  // Handshake is masked during reset so no beat slips through while the grant is being dropped.
  assign grant_idx = grant_q;
  assign out_data  = req_data[int'(grant_q)*WIDTH +: WIDTH];
  assign out_valid = !rst_in && busy && g_valid;

  always_comb begin
    req_ready = '0;
    if (!rst_in && busy) req_ready[grant_q] = out_ready;
  end

endmodule
